// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the program image loader.
package program_loader_pkg;

  localparam int CODE_BYTES = 256;
  localparam int BYTE_W     = 8;
  localparam int CODE_W     = 2048;

  localparam logic [7:0] HALT_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN) || (s == ST_LOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit running-sum accumulator over the payload bytes of one image.
module loader_checksum
  import program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [BYTE_W-1:0] sum_o
);

  logic [BYTE_W-1:0] sum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sum_q <= 8'h00;
    end else if (en_i) begin
      sum_q <= sum_q + din_i;
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program image into a flat code
// register and releases the downstream CPU from reset once it verifies.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [CODE_W-1:0] code,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              error,
  output logic [8:0]        bytes_loaded
);

  state_t              state_q, state_d;
  logic [8:0]          remaining_q;
  logic [8:0]          bytes_loaded_q;
  logic [CODE_W-1:0]   code_q;
  logic                byte_ready_q, cpu_reset_q, loaded_q, error_q;
  logic [BYTE_W-1:0]   sum_s;
  logic [CODE_BYTES-1:0] we_s;
  logic                xfer_s, load_wr_s;

  assign xfer_s    = byte_valid && byte_ready_q;
  assign load_wr_s = xfer_s && (state_q == ST_LOAD) && !start;

  loader_checksum u_checksum (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (start),
    .en_i  (load_wr_s),
    .din_i (byte_data),
    .sum_o (sum_s)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_LEN;
    end else begin
      case (state_q)
        ST_LEN:  state_d = xfer_s ? ST_LOAD : ST_LEN;
        ST_LOAD: state_d = (xfer_s && (remaining_q == 9'd1)) ? ST_CHK : ST_LOAD;
        ST_CHK:  state_d = !xfer_s ? ST_CHK : ((byte_data == sum_s) ? ST_RUN : ST_ERR);
        default: state_d = state_q;
      endcase
    end
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      remaining_q    <= 9'd0;
      bytes_loaded_q <= 9'd0;
      byte_ready_q   <= 1'b0;
      cpu_reset_q    <= 1'b1;
      loaded_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= accepts_bytes(state_d);
      cpu_reset_q  <= (state_d != ST_RUN);
      loaded_q     <= (state_d == ST_RUN);
      error_q      <= (state_d == ST_ERR);
      if (start) begin
        remaining_q    <= 9'd0;
        bytes_loaded_q <= 9'd0;
      end else if (xfer_s && (state_q == ST_LEN)) begin
        remaining_q    <= (byte_data == 8'h00) ? 9'd256 : {1'b0, byte_data};
        bytes_loaded_q <= bytes_loaded_q;
      end else if (load_wr_s) begin
        remaining_q    <= remaining_q - 9'd1;
        bytes_loaded_q <= bytes_loaded_q + 9'd1;
      end else begin
        remaining_q    <= remaining_q;
        bytes_loaded_q <= bytes_loaded_q;
      end
    end
  end

  always_comb begin
    we_s = '0;
    we_s[bytes_loaded_q[7:0]] = load_wr_s;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CODE_BYTES; i++) begin
      if (reset || start) begin
        code_q[i*BYTE_W +: BYTE_W] <= HALT_OPCODE;
      end else if (we_s[i]) begin
        code_q[i*BYTE_W +: BYTE_W] <= byte_data;
      end else begin
        code_q[i*BYTE_W +: BYTE_W] <= code_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign byte_ready   = byte_ready_q;
  assign code         = code_q;
  assign cpu_reset    = cpu_reset_q;
  assign loaded       = loaded_q;
  assign error        = error_q;
  assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: image loads, checksum failure, full image,
// gapped streams, stray input, restart and reset during a load.
module tb_program_loader;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic [2047:0] code;
  logic          cpu_reset, loaded, error;
  logic [8:0]    bytes_loaded;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_img [256];

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .code         (code),
    .cpu_reset    (cpu_reset),
    .loaded       (loaded),
    .error        (error),
    .bytes_loaded (bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) exp_img[i] = 8'h00;
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (code[i*8 +: 8] !== exp_img[i]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a falling edge; waits (bounded) for byte_ready.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_ready"},     64'(byte_ready), 64'd0);
    check({tag, "_loaded"},    64'(loaded), 64'd0);
    check({tag, "_error"},     64'(error), 64'd0);
    check({tag, "_bytes"},     64'(bytes_loaded), 64'd0);
    clear_model();
    check_image({tag, "_code"});
  endtask

  task automatic small_load(input logic [7:0] csum, input bit gaps);
    pulse_start();
    send_byte(8'h03, gaps);
    send_byte(8'h01, gaps);
    send_byte(8'h00, gaps);
    send_byte(8'h05, gaps);
    check("pre_chk_loaded", 64'(loaded), 64'd0);
    send_byte(csum, gaps);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    // stray byte_valid in IDLE
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_reset_state("idle_stray");

    // good load
    small_load(8'h06, 1'b0);
    clear_model();
    exp_img[0] = 8'h01; exp_img[1] = 8'h00; exp_img[2] = 8'h05;
    check("good_code_lo", 64'(code[23:0]), 64'h050001);
    check_image("good_image");
    check("good_bytes", 64'(bytes_loaded), 64'd3);
    check("good_loaded", 64'(loaded), 64'd1);
    check("good_cpu_reset", 64'(cpu_reset), 64'd0);
    check("good_ready", 64'(byte_ready), 64'd0);

    // stray input in RUN leaves the image alone
    byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_image("run_stray_image");
    check("run_stray_loaded", 64'(loaded), 64'd1);

    // start while RUN re-asserts cpu_reset next cycle
    pulse_start();
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    check("restart_loaded", 64'(loaded), 64'd0);
    check("restart_code", 64'(code[63:0]), 64'd0);

    // bad checksum
    small_load(8'h07, 1'b0);
    check("bad_error", 64'(error), 64'd1);
    check("bad_cpu_reset", 64'(cpu_reset), 64'd1);
    check("bad_ready", 64'(byte_ready), 64'd0);
    check("bad_loaded", 64'(loaded), 64'd0);

    // gapped stream gives the same image
    small_load(8'h06, 1'b1);
    clear_model();
    exp_img[0] = 8'h01; exp_img[1] = 8'h00; exp_img[2] = 8'h05;
    check_image("gap_image");
    check("gap_loaded", 64'(loaded), 64'd1);
    check("gap_error", 64'(error), 64'd0);

    // full 256-byte image, sum 0..255 = 0x80
    pulse_start();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b0);
      exp_img[i] = 8'(i);
    end
    check("full_bytes_mid", 64'(bytes_loaded), 64'd256);
    check("full_ready_chk", 64'(byte_ready), 64'd1);
    send_byte(8'h80, 1'b0);
    check("full_bytes", 64'(bytes_loaded), 64'd256);
    check("full_top_byte", 64'(code[2047:2040]), 64'hFF);
    check_image("full_image");
    check("full_loaded", 64'(loaded), 64'd1);

    // restart mid-load returns to LEN with a clean image
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("mid_bytes_before", 64'(bytes_loaded), 64'd2);
    pulse_start();
    check("mid_restart_bytes", 64'(bytes_loaded), 64'd0);
    check("mid_restart_code", 64'(code[63:0]), 64'd0);
    check("mid_restart_ready", 64'(byte_ready), 64'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b0);
    check("mid_restart_loaded", 64'(loaded), 64'd1);
    check("mid_restart_img", 64'(code[15:0]), 64'h003C);

    // reset mid-load
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset();
    check_reset_state("mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
